frame_sched: RTL and testbench

//  Frame-level scheduler for the render datapath (ppl -> map -> align).
//  On each frame request it latches the player pose, streams every pixel

---
 rtl/frame_sched_if.sv | 27 ++
 rtl/frame_sched.sv | 179 +++++++++++++++++
 tb/tb_frame_sched.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sched_if.sv
// Render-side bus of the frame scheduler: pixel-address stream to ppl and
// the map block-write port with its edit request/acknowledge pair.
interface frame_sched_if;
    // pix: a transfer happens in every cycle where pix_valid && pix_ready;
    // once raised, pix_valid and pix_addr hold until that transfer.
    // edit: edit_req/addr/data hold until the one-cycle edit_ack.
    logic        pix_valid;
    logic        pix_ready;
    logic [19:0] pix_addr;
    logic        edit_req;
    logic [14:0] edit_addr;
    logic [4:0]  edit_data;
    logic        edit_ack;
    logic        write_en;
    logic [14:0] write_addr;
    logic [4:0]  write_data;

    modport master (
        output pix_valid, pix_addr, edit_ack, write_en, write_addr, write_data,
        input  pix_ready, edit_req, edit_addr, edit_data
    );

    modport slave (
        input  pix_valid, pix_addr, edit_ack, write_en, write_addr, write_data,
        output pix_ready, edit_req, edit_addr, edit_data
    );
endinterface

// File: rtl/frame_sched.sv
// Frame scheduler: freezes the pose, streams every pixel address of a frame,
// waits for the pipeline to drain, and lets map edits in only between frames.
module frame_sched #(
    parameter int H_DISP    = 32,
    parameter int V_DISP    = 24,
    parameter int DRAIN_CYC = 16,
    parameter int POS_W     = 18,
    parameter int ANG_W     = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_frame_req,
    input  logic [POS_W-1:0] i_pos_x,
    input  logic [POS_W-1:0] i_pos_y,
    input  logic [POS_W-1:0] i_pos_z,
    input  logic [ANG_W-1:0] i_ang_x,
    input  logic [ANG_W-1:0] i_ang_y,
    output logic [POS_W-1:0] o_p_pos_x,
    output logic [POS_W-1:0] o_p_pos_y,
    output logic [POS_W-1:0] o_p_pos_z,
    output logic [ANG_W-1:0] o_p_angle_x,
    output logic [ANG_W-1:0] o_p_angle_y,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic [7:0]       o_overrun_cnt,
    output logic [1:0]       o_state,
    frame_sched_if.master    bus
);

    localparam int XW = (H_DISP > 1) ? $clog2(H_DISP) : 1;
    localparam int YW = (V_DISP > 1) ? $clog2(V_DISP) : 1;
    localparam int CW = $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic [19:0]      r_addr;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic [7:0]       r_ovr;
    logic [POS_W-1:0] r_p_pos_x;
    logic [POS_W-1:0] r_p_pos_y;
    logic [POS_W-1:0] r_p_pos_z;
    logic [ANG_W-1:0] r_p_ang_x;
    logic [ANG_W-1:0] r_p_ang_y;

    logic          w_xfer;
    logic          w_x_end;
    logic          w_y_end;
    logic          w_last;
    logic          w_drain_end;
    logic          w_edit_fire;
    logic [XW-1:0] w_x_nxt;
    logic [YW-1:0] w_y_nxt;
    logic [19:0]   w_addr_nxt;

    assign w_xfer      = (r_state == S_RUN) && bus.pix_ready;
    assign w_x_end     = (r_x == XW'(H_DISP - 1));
    assign w_y_end     = (r_y == YW'(V_DISP - 1));
    assign w_last      = w_xfer && w_x_end && w_y_end;
    assign w_drain_end = (r_state == S_DRAIN) && (r_cnt == CW'(DRAIN_CYC - 1));

    // Raster position advances only on an accepted address, so a stall can
    // neither skip nor repeat a pixel.
    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (r_state == S_LATCH) begin
            w_x_nxt = '0;
            w_y_nxt = '0;
        end else if (w_xfer) begin
            if (w_x_end) begin
                w_x_nxt = '0;
                w_y_nxt = w_y_end ? '0 : r_y + 1'b1;
            end else begin
                w_x_nxt = r_x + 1'b1;
            end
        end
    end

    assign w_addr_nxt = 20'(w_y_nxt) * 20'(H_DISP) + 20'(w_x_nxt);

    always_comb begin
        w_state_nxt = r_state;
        w_edit_fire = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A coinciding frame request wins; the edit waits for the next IDLE.
                if (i_frame_req) begin
                    w_state_nxt = S_LATCH;
                end else if (bus.edit_req) begin
                    w_edit_fire = 1'b1;
                end
            end
            S_LATCH: w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_drain_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_addr  <= w_addr_nxt;
            r_cnt   <= (r_state == S_DRAIN) ? r_cnt + 1'b1 : '0;
            r_done  <= w_drain_end;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_pos_x <= '0;
            r_p_pos_y <= '0;
            r_p_pos_z <= '0;
            r_p_ang_x <= '0;
            r_p_ang_y <= '0;
        end else if (r_state == S_LATCH) begin
            r_p_pos_x <= i_pos_x;
            r_p_pos_y <= i_pos_y;
            r_p_pos_z <= i_pos_z;
            r_p_ang_x <= i_ang_x;
            r_p_ang_y <= i_ang_y;
        end
    end

    // Requests arriving while a frame is in flight are dropped, not queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovr <= '0;
        end else if (i_frame_req && (r_state != S_IDLE) && (r_ovr != 8'hFF)) begin
            r_ovr <= r_ovr + 8'd1;
        end
    end

    assign bus.pix_valid  = (r_state == S_RUN);
    assign bus.pix_addr   = r_addr;
    assign bus.edit_ack   = w_edit_fire;
    assign bus.write_en   = w_edit_fire;
    assign bus.write_addr = w_edit_fire ? bus.edit_addr : '0;
    assign bus.write_data = w_edit_fire ? bus.edit_data : '0;

    assign o_p_pos_x     = r_p_pos_x;
    assign o_p_pos_y     = r_p_pos_y;
    assign o_p_pos_z     = r_p_pos_z;
    assign o_p_angle_x   = r_p_ang_x;
    assign o_p_angle_y   = r_p_ang_y;
    assign o_busy        = (r_state != S_IDLE);
    assign o_frame_done  = r_done;
    assign o_overrun_cnt = r_ovr;
    assign o_state       = r_state;

endmodule

// File: tb/tb_frame_sched.sv
// Bench for frame_sched: expected pixel addresses and edits are queued as
// stimulus is issued; a negedge monitor pops and compares them.
module tb_frame_sched;
  localparam int H  = 32;
  localparam int V  = 24;
  localparam int NP = H * V;
  localparam int DR = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_req = 1'b0;
  logic [17:0] pos_x = '0, pos_y = '0, pos_z = '0;
  logic [19:0] ang_x = '0, ang_y = '0;
  logic [17:0] p_pos_x, p_pos_y, p_pos_z;
  logic [19:0] p_ang_x, p_ang_y;
  logic        busy, frame_done;
  logic [7:0]  overrun_cnt;
  logic [1:0]  state;

  frame_sched_if u_if ();

  frame_sched #(.H_DISP(H), .V_DISP(V), .DRAIN_CYC(DR), .POS_W(18), .ANG_W(20)) dut (
    .clk(clk), .rst(rst), .i_frame_req(frame_req),
    .i_pos_x(pos_x), .i_pos_y(pos_y), .i_pos_z(pos_z),
    .i_ang_x(ang_x), .i_ang_y(ang_y),
    .o_p_pos_x(p_pos_x), .o_p_pos_y(p_pos_y), .o_p_pos_z(p_pos_z),
    .o_p_angle_x(p_ang_x), .o_p_angle_y(p_ang_y),
    .o_busy(busy), .o_frame_done(frame_done), .o_overrun_cnt(overrun_cnt),
    .o_state(state), .bus(u_if)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [19:0] exp_q[$];
  logic [19:0] exp_e[$];
  int n_chk = 0, n_pass = 0;
  int fd_cnt = 0, req_cyc = 0, last_xfer_cyc = 0, done_cyc = -1, edit_cyc = -2;
  logic prev_valid = 1'b0, prev_stall = 1'b0;
  logic [19:0] prev_addr = '0;
  bit toggle_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: event not expected or not seen in time", name);
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", u_if.pix_valid, 1);
        chk("stall_addr", u_if.pix_addr, prev_addr);
      end
      if (u_if.pix_valid && !prev_valid) chk("first_valid_latency", cyc - req_cyc, 2);
      if (u_if.pix_valid && u_if.pix_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_transfer");
        else chk("pix_addr", u_if.pix_addr, exp_q.pop_front());
        last_xfer_cyc = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        done_cyc = cyc;
        chk("done_latency", cyc - last_xfer_cyc, DR + 1);
        chk("busy_at_done", busy, 0);
      end
      if (u_if.write_en) begin
        edit_cyc = cyc;
        if (exp_e.size() == 0) fail_now("unexpected_edit");
        else chk("edit_word", {u_if.write_addr, u_if.write_data}, exp_e.pop_front());
        chk("edit_ack", u_if.edit_ack, 1);
        chk("edit_busy", busy, 0);
        chk("edit_vs_frame_req", frame_req, 0);
      end
      prev_valid = u_if.pix_valid;
      prev_stall = u_if.pix_valid && !u_if.pix_ready;
      prev_addr  = u_if.pix_addr;
    end
  end

  // driver tasks
  task automatic step();
    logic ack_now;
    @(negedge clk);
    ack_now = u_if.edit_ack;
    @(posedge clk);
    #1;
    if (ack_now) u_if.edit_req = 1'b0;
    if (toggle_ready) u_if.pix_ready = ~u_if.pix_ready;
  endtask

  task automatic push_frame();
    for (int i = 0; i < NP; i++) exp_q.push_back(20'(i));
  endtask

  task automatic start_frame();
    frame_req = 1'b1;
    req_cyc = cyc;
    step();
    frame_req = 1'b0;
  endtask

  task automatic drop_pulse();
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    step();
  endtask

  task automatic wait_done(input int budget);
    int s = fd_cnt;
    int k = 0;
    while (fd_cnt == s && k < budget) begin
      step();
      k++;
    end
    if (fd_cnt == s) fail_now("frame_done_timeout");
    chk("exp_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    int s;
    int k;
    u_if.pix_ready = 1'b1;
    u_if.edit_req  = 1'b0;
    u_if.edit_addr = '0;
    u_if.edit_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", u_if.pix_valid, 0);
    chk("rst_addr", u_if.pix_addr, 0);
    chk("rst_ovr", overrun_cnt, 0);
    chk("rst_pose", p_pos_x, 0);
    rst = 1'b0;
    step();

    // T1 + T3: full frame at pix_ready=1, pose frozen while live pose changes
    pos_x = 18'(170 << 8); pos_y = 18'd1234; pos_z = 18'd777;
    ang_x = 20'd99999;     ang_y = 20'd4321;
    push_frame();
    start_frame();
    chk("latch_busy", busy, 1);
    repeat (50) step();
    pos_x = '0;
    wait_done(2000);
    chk("t1_busy_after", busy, 0);
    chk("t1_valid_after", u_if.pix_valid, 0);
    chk("t3_p_pos_x", p_pos_x, 43520);
    chk("t3_p_pos_y", p_pos_y, 1234);
    chk("t3_p_pos_z", p_pos_z, 777);
    chk("t3_p_ang_x", p_ang_x, 99999);
    chk("t3_p_ang_y", p_ang_y, 4321);

    // T2: backpressure toggling every cycle; next LATCH picks up pos_x=0
    toggle_ready = 1'b1;
    push_frame();
    start_frame();
    wait_done(4000);
    toggle_ready = 1'b0;
    u_if.pix_ready = 1'b1;
    chk("t2_p_pos_x_relatch", p_pos_x, 0);

    // T4a: edit raised mid-RUN lands in the first IDLE cycle
    push_frame();
    start_frame();
    repeat (100) step();
    u_if.edit_addr = 15'h1234;
    u_if.edit_data = 5'd5;
    u_if.edit_req  = 1'b1;
    exp_e.push_back({15'h1234, 5'd5});
    wait_done(2000);
    step();
    step();
    chk("t4a_edit_at_done", edit_cyc, done_cyc);
    chk("t4a_edit_q_empty", exp_e.size(), 0);

    // T4b: edit and frame request coincide in IDLE; frame goes first
    u_if.edit_addr = 15'h0abc;
    u_if.edit_data = 5'd17;
    u_if.edit_req  = 1'b1;
    exp_e.push_back({15'h0abc, 5'd17});
    push_frame();
    start_frame();
    chk("t4b_frame_first", busy, 1);
    wait_done(2000);
    step();
    chk("t4b_edit_at_done", edit_cyc, done_cyc);
    chk("t4b_edit_q_empty", exp_e.size(), 0);

    // T5: dropped requests, then saturation
    push_frame();
    start_frame();
    repeat (10) step();
    repeat (3) drop_pulse();
    wait_done(2000);
    chk("t5_ovr_3", overrun_cnt, 3);
    push_frame();
    start_frame();
    repeat (5) step();
    repeat (300) drop_pulse();
    wait_done(2000);
    chk("t5_ovr_sat", overrun_cnt, 255);

    // T6: asynchronous reset at address 400
    pos_x = 18'd5555;
    push_frame();
    start_frame();
    k = 0;
    while (!(u_if.pix_valid && u_if.pix_addr == 20'd400) && k < 2000) begin
      step();
      k++;
    end
    if (k >= 2000) fail_now("t6_addr400_timeout");
    chk("t6_pose_before", p_pos_x, 5555);
    s = fd_cnt;
    rst = 1'b1;
    #1;
    chk("t6_valid", u_if.pix_valid, 0);
    chk("t6_addr", u_if.pix_addr, 0);
    chk("t6_busy", busy, 0);
    chk("t6_state", state, 0);
    chk("t6_ovr", overrun_cnt, 0);
    chk("t6_pose", p_pos_x, 0);
    chk("t6_done", frame_done, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) step();
    chk("t6_no_frame_done", fd_cnt, s);
    push_frame();
    start_frame();
    wait_done(2000);
    chk("t6_restart_pose", p_pos_x, 5555);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
